// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, fetches words over req/ack, presents one instruction to ID.
// A one-entry skid slot catches the word already in flight when a stall arrives.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  typedef enum logic {ST_RUN, ST_DROP} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic        r_req, w_req_nxt;
  logic [31:0] r_tgt, w_tgt_nxt;
  logic        r_o_vld, w_o_vld_nxt;
  logic [31:0] r_o_pc, w_o_pc_nxt;
  logic [31:0] r_o_inst, w_o_inst_nxt;
  logic        r_s_vld, w_s_vld_nxt;
  logic [31:0] r_s_pc, w_s_pc_nxt;
  logic [31:0] r_s_inst, w_s_inst_nxt;

  logic        w_ack;
  logic        w_cons;
  logic [31:0] w_br_tgt;

  assign w_ack    = r_req & mem_ack;
  assign w_cons   = r_o_vld & ~stall;
  assign w_br_tgt = {branch_target[31:2], 2'b00};

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_req_nxt    = r_req;
    w_tgt_nxt    = r_tgt;
    w_o_vld_nxt  = r_o_vld;
    w_o_pc_nxt   = r_o_pc;
    w_o_inst_nxt = r_o_inst;
    w_s_vld_nxt  = r_s_vld;
    w_s_pc_nxt   = r_s_pc;
    w_s_inst_nxt = r_s_inst;

    if (branch_flag) begin
      w_o_vld_nxt  = 1'b0;
      w_o_pc_nxt   = 32'h0;
      w_o_inst_nxt = 32'h0;
      w_s_vld_nxt  = 1'b0;
      w_s_pc_nxt   = 32'h0;
      w_s_inst_nxt = 32'h0;
      // A still-pending request must complete before the bus may move to the target.
      if (!r_req || w_ack) begin
        w_pc_nxt    = w_br_tgt;
        w_req_nxt   = 1'b1;
        w_state_nxt = ST_RUN;
      end else begin
        w_tgt_nxt   = w_br_tgt;
        w_state_nxt = ST_DROP;
      end
    end else if (r_state == ST_DROP) begin
      if (w_ack) begin
        w_pc_nxt    = r_tgt;
        w_state_nxt = ST_RUN;
      end
    end else begin
      if (w_ack) begin
        w_pc_nxt = r_pc + 32'd4;
        if ((!r_o_vld || w_cons) && !r_s_vld) begin
          w_o_vld_nxt  = 1'b1;
          w_o_pc_nxt   = r_pc;
          w_o_inst_nxt = mem_rdata;
        end else if (w_cons) begin
          w_o_vld_nxt  = 1'b1;
          w_o_pc_nxt   = r_s_pc;
          w_o_inst_nxt = r_s_inst;
          w_s_vld_nxt  = 1'b1;
          w_s_pc_nxt   = r_pc;
          w_s_inst_nxt = mem_rdata;
        end else begin
          w_s_vld_nxt  = 1'b1;
          w_s_pc_nxt   = r_pc;
          w_s_inst_nxt = mem_rdata;
        end
      end else if (w_cons) begin
        if (r_s_vld) begin
          w_o_vld_nxt  = 1'b1;
          w_o_pc_nxt   = r_s_pc;
          w_o_inst_nxt = r_s_inst;
          w_s_vld_nxt  = 1'b0;
          w_s_pc_nxt   = 32'h0;
          w_s_inst_nxt = 32'h0;
        end else begin
          w_o_vld_nxt  = 1'b0;
          w_o_pc_nxt   = 32'h0;
          w_o_inst_nxt = 32'h0;
        end
      end
      // Requesting only while the skid slot stays empty keeps acks from ever overflowing it.
      w_req_nxt = ~w_s_vld_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_RUN;
      r_pc     <= RESET_PC;
      r_req    <= 1'b0;
      r_tgt    <= RESET_PC;
      r_o_vld  <= 1'b0;
      r_o_pc   <= 32'h0;
      r_o_inst <= 32'h0;
      r_s_vld  <= 1'b0;
      r_s_pc   <= 32'h0;
      r_s_inst <= 32'h0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_req    <= w_req_nxt;
      r_tgt    <= w_tgt_nxt;
      r_o_vld  <= w_o_vld_nxt;
      r_o_pc   <= w_o_pc_nxt;
      r_o_inst <= w_o_inst_nxt;
      r_s_vld  <= w_s_vld_nxt;
      r_s_pc   <= w_s_pc_nxt;
      r_s_inst <= w_s_inst_nxt;
    end
  end

  assign mem_req  = r_req;
  assign mem_addr = r_pc;
  assign if_valid = r_o_vld;
  assign if_pc    = r_o_pc;
  assign if_inst  = r_o_inst;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: memory model with random latency, directed scenarios, random stall/branch/reset.
// Reference: delivered stream is a linear PC walk restarted at each branch target or reset.
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] KEY      = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;

  int errors = 0;
  int checks = 0;
  int lat_min = 0;
  int lat_max = 0;
  int n_deliv = 0;
  logic [31:0] redir_q[$];
  logic [31:0] exp_pc = RESET_PC;

  if_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_flag(branch_flag), .branch_target(branch_target),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    stall = 1'b0;
    branch_flag = 1'b0;
    repeat (3) step();
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    rst = 1'b1;
  endtask

  task automatic branch(input logic [31:0] t);
    branch_flag = 1'b1;
    branch_target = t;
    redir_q.push_back({t[31:2], 2'b00});
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (if_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (if_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: if_valid never rose, got %b expected 1", name, if_valid);
    end
  endtask

  // Instruction memory: holds data = addr ^ KEY, acks after a random wait, reset with rst.
  initial begin
    int lat;
    bit fresh;
    lat = 0;
    fresh = 1'b1;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ack) fresh = 1'b1;
      if (rst !== 1'b1 || !mem_req) begin
        mem_ack = ($urandom_range(0, 3) == 0);
        mem_rdata = $urandom;
        fresh = 1'b1;
      end else begin
        if (fresh) begin
          lat = $urandom_range(lat_max, lat_min);
          fresh = 1'b0;
        end
        if (lat == 0) begin
          mem_ack = 1'b1;
          mem_rdata = mem_addr ^ KEY;
        end else begin
          mem_ack = 1'b0;
          mem_rdata = $urandom;
          lat--;
        end
      end
    end
  end

  // Monitor: values at the negedge are what the next rising edge acts on.
  initial begin
    logic p_rst_low, p_rst, p_req, p_ack;
    logic [31:0] p_addr;
    p_rst_low = 1'b0; p_rst = 1'b0; p_req = 1'b0; p_ack = 1'b0; p_addr = 32'h0;
    forever begin
      @(negedge clk);
      if (p_rst_low) begin
        chk("reset_req", 32'(mem_req), 32'd0);
        chk("reset_addr", mem_addr, RESET_PC);
        chk("reset_valid", 32'(if_valid), 32'd0);
        chk("reset_pc", if_pc, 32'd0);
        chk("reset_inst", if_inst, 32'd0);
      end
      if (p_rst && p_req && !p_ack) begin
        chk("req_hold", 32'(mem_req), 32'd1);
        chk("addr_hold", mem_addr, p_addr);
      end
      if (if_valid !== 1'b1) chk("nop_inst", if_inst, 32'd0);
      if (rst !== 1'b1) begin
        exp_pc = RESET_PC;
        redir_q.delete();
      end else begin
        if (if_valid === 1'b1 && stall === 1'b0) begin
          chk("deliv_pc", if_pc, exp_pc);
          chk("deliv_inst", if_inst, exp_pc ^ KEY);
          exp_pc = exp_pc + 32'd4;
          n_deliv++;
        end
        if (branch_flag === 1'b1) begin
          if (redir_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL redir_q: got empty queue expected a target");
          end else begin
            exp_pc = redir_q.pop_front();
          end
        end
      end
      p_rst_low = (rst !== 1'b1);
      p_rst = (rst === 1'b1);
      p_req = mem_req;
      p_ack = mem_ack;
      p_addr = mem_addr;
    end
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    stall = 1'b0;
    branch_flag = 1'b0;
    branch_target = 32'h0;

    // Zero-wait streaming, then a 3-cycle stall with a word caught in flight.
    lat_min = 0; lat_max = 0;
    do_reset();
    step();
    chk("a_req", 32'(mem_req), 32'd1);
    chk("a_addr0", mem_addr, 32'h0);
    chk("a_valid0", 32'(if_valid), 32'd0);
    step();
    chk("a_addr4", mem_addr, 32'h4);
    chk("a_valid1", 32'(if_valid), 32'd1);
    chk("a_pc0", if_pc, 32'h0);
    step();
    chk("a_addr8", mem_addr, 32'h8);
    chk("a_pc4", if_pc, 32'h4);
    step();
    chk("a_addr12", mem_addr, 32'hC);
    chk("a_pc8", if_pc, 32'h8);
    stall = 1'b1;
    step();
    chk("b_hold_pc", if_pc, 32'h8);
    chk("b_req_off", 32'(mem_req), 32'd0);
    step();
    step();
    chk("b_hold_pc3", if_pc, 32'h8);
    chk("b_req_off3", 32'(mem_req), 32'd0);
    stall = 1'b0;
    step();
    chk("b_pc_c", if_pc, 32'hC);
    chk("b_req_on", 32'(mem_req), 32'd1);
    chk("b_addr10", mem_addr, 32'h10);
    step();
    chk("b_pc_10", if_pc, 32'h10);

    // Branch while a slow fetch is pending: old data dropped.
    lat_min = 3; lat_max = 3;
    do_reset();
    step();
    step();
    branch(32'h0000_0100);
    step();
    branch_flag = 1'b0;
    chk("c_valid_drop", 32'(if_valid), 32'd0);
    chk("c_addr_hold", mem_addr, 32'h0);
    step();
    step();
    chk("c_addr_tgt", mem_addr, 32'h100);
    chk("c_valid_off", 32'(if_valid), 32'd0);
    wait_valid("c_wait");
    chk("c_pc_tgt", if_pc, 32'h100);

    // Branch with stall held and the skid slot full; target low bits masked.
    lat_min = 0; lat_max = 0;
    do_reset();
    step();
    step();
    stall = 1'b1;
    step();
    chk("d_req_off", 32'(mem_req), 32'd0);
    chk("d_pc0", if_pc, 32'h0);
    branch(32'h0000_0207);
    step();
    branch_flag = 1'b0;
    chk("d_valid_flush", 32'(if_valid), 32'd0);
    chk("d_inst_flush", if_inst, 32'h0);
    chk("d_req_on", 32'(mem_req), 32'd1);
    chk("d_addr_tgt", mem_addr, 32'h204);
    stall = 1'b0;
    wait_valid("d_wait");
    chk("d_pc_tgt", if_pc, 32'h204);

    // Two branches in one drop window: last one wins.
    lat_min = 3; lat_max = 3;
    do_reset();
    step();
    branch(32'h0000_0040);
    step();
    branch_flag = 1'b0;
    step();
    branch(32'h0000_0080);
    step();
    branch_flag = 1'b0;
    step();
    chk("e_addr_tgt", mem_addr, 32'h80);
    chk("e_valid_off", 32'(if_valid), 32'd0);
    wait_valid("e_wait");
    chk("e_pc_tgt", if_pc, 32'h80);

    // Reset with output and skid slots full, then restart.
    lat_min = 0; lat_max = 0;
    do_reset();
    step();
    step();
    stall = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("f_valid_rst", 32'(if_valid), 32'd0);
    chk("f_addr_rst", mem_addr, RESET_PC);
    chk("f_req_rst", 32'(mem_req), 32'd0);
    stall = 1'b0;
    rst = 1'b1;
    step();
    chk("f_req_on", 32'(mem_req), 32'd1);
    chk("f_addr_on", mem_addr, RESET_PC);
    wait_valid("f_wait");
    chk("f_pc_restart", if_pc, RESET_PC);

    // PC wrap at the top of the address space.
    branch(32'hFFFF_FFF8);
    step();
    branch_flag = 1'b0;
    repeat (8) step();

    // Random stall/branch/reset with varying memory latency.
    for (int blk = 0; blk < 8; blk++) begin
      lat_min = 0;
      lat_max = $urandom_range(0, 3);
      for (int c = 0; c < 500; c++) begin
        branch_flag = 1'b0;
        if ($urandom_range(0, 299) == 0) begin
          rst = 1'b0;
          stall = 1'b0;
          step();
          step();
          rst = 1'b1;
        end else begin
          stall = ($urandom_range(0, 3) == 0);
          if ($urandom_range(0, 19) == 0) branch($urandom);
        end
        step();
      end
    end
    branch_flag = 1'b0;
    stall = 1'b0;
    repeat (5) step();
    chk("liveness", 32'(n_deliv > 200), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the ToruMIPS pipeline, directly upstream of `if_id`. Owns the program counter, issues word fetches to instruction memory over a req/ack handshake, and presents `if_pc`/`if_inst`/`if_valid` to `if_id`. Includes a one-entry skid buffer so a stall arriving with a fetch in flight loses no instruction. Also redirects the PC and flushes in-flight fetches on a branch resolved in ID.

## Interface
- `RESET_PC`, default 32'h0000_0000, first fetch address after reset (word-aligned).

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-low (rst==0 resets on the clock edge).
- `stall`  in  1  downstream hold; 1 = `if_id` will not take the instruction this cycle.
- `branch_flag`  in  1  one-cycle redirect request from ID.
- `branch_target`  in  32  redirect address; bits [1:0] are ignored and forced to 0.
- `mem_req`  out  1  fetch request; registered.
- `mem_addr`  out  32  fetch address; registered, stable while `mem_req`=1 and unacked.
- `mem_ack`  in  1  memory accepts the request; `mem_rdata` is valid in this cycle. May be asserted in the same cycle `mem_req` first goes high.
- `mem_rdata`  in  32  instruction word.
- `if_pc`  out  32  PC of the presented instruction.
- `if_inst`  out  32  presented instruction; 32'h0 (NOP) whenever `if_valid`=0.
- `if_valid`  out  1  output slot holds a real instruction.

## Operation
- Storage: fetch PC `pc`, output slot O (`if_valid`/`if_pc`/`if_inst`), skid slot S (valid/pc/inst), saved redirect target `tgt`, state {RUN, DROP}.
- Transfer to `if_id` occurs on an edge where `if_valid`=1 and `stall`=0 (consume).
- Memory protocol: once `mem_req`=1, `mem_req` and `mem_addr` hold until the cycle with `mem_ack`=1. `mem_ack` while `mem_req`=0 is ignored.
- RUN, edge with `mem_ack`=1 (accepted data D at address `pc`):
  - `pc` <= `pc`+4 (modulo 2^32, wraps at 32'hFFFF_FFFC -> 0).
  - If O empty or consumed, and S empty: O <= D.
  - If O consumed and S full: O <= S, S <= D.
  - If O full and not consumed: S <= D (S is guaranteed empty, see below).
- Consume without ack: O <= S and S cleared if S full; else O emptied (`if_inst`=0).
- Next `mem_req` = 1 unless S will be full after this edge; `mem_addr` follows `pc`. Therefore an ack never arrives with S full.
- Order is strict: S drains before any newer ack data enters O.
- Branch (`branch_flag`=1 on an edge, any state, regardless of `stall`):
  - O and S flushed (`if_valid`=0, `if_inst`=0); any ack data in this cycle is discarded.
  - If no unacked request remains after the edge (`mem_req`=0, or `mem_ack`=1 this cycle): `pc` <= target; `mem_req`=1, `mem_addr`=target next cycle; state RUN.
  - Else: `tgt` <= target, state DROP; `mem_req`/`mem_addr` hold old values.
- DROP:
  - On `mem_ack`: data discarded, `pc` <= `tgt`, `mem_addr`=`tgt` next cycle, state RUN.
  - A further branch in DROP overwrites `tgt` (last branch wins). If it coincides with the ack, the new target is used.
- Reset (any time, including mid-request):
  - `pc`=`RESET_PC`, `mem_req`=0, `mem_addr`=`RESET_PC`, `if_valid`=0, `if_pc`=0, `if_inst`=0, S empty, state RUN.
  - Any outstanding memory request is abandoned; instruction memory is reset by the same `rst`.

## Timing
- First edge with `rst`=1 sets `mem_req`=1, `mem_addr`=`RESET_PC`.
- Fetch latency: ack in cycle N -> `if_valid`=1 with that instruction from cycle N+1.
- With zero-wait memory (ack every cycle `mem_req`=1) and no stall: throughput is 1 instruction/cycle, PCs RESET_PC, +4, +8, ...
- Stall asserted in cycle N with a fetch acked in N: that word goes to S. `mem_req`=0 from N+1 until S drains.
- Stall released at edge M: O <= S at M, `mem_req`=1 from M+1. No duplicate, no lost word.
- Branch at edge B (RUN, no pending): `if_valid`=0 from B+1, `mem_addr`=target from B+1. The first target instruction is valid at B+2 with a zero-wait ack.
- `if_pc`/`if_inst` are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset release, RESET_PC=0, zero-wait memory returning {addr} -> `mem_addr` 0,4,8,12 in consecutive cycles. `if_pc`/`if_inst` 0,4,8 valid one cycle later each. During reset all outputs are 0.
- `stall` high 3 cycles from the cycle instruction @8 is presented, with ack in the same cycle -> @8 held; @C captured in S; `mem_req`=0. On release @8, @C, @10 are consumed in order with no gaps or duplicates.
- Memory with 3-cycle ack latency; `branch_flag`, target 32'h0000_0100, one cycle after `mem_req` rises -> old ack discarded, `if_valid`=0 through. Next `mem_addr`=0x100; next valid `if_pc`=0x100.
- Branch coincident with `stall`=1 and S full, target 0x204 (bits[1:0]=00 after masking from 0x207) -> O and S flushed next edge, `mem_addr`=0x204.
- Two branches (0x40 then 0x80) during a single DROP -> only 0x80 fetched; no instruction from 0x40 or the old stream ever has `if_valid`=1.
- `rst`=0 asserted mid-request with O and S full -> next cycle all outputs at reset values. After release, fetch restarts at RESET_PC and the stale ack is ignored.
